execute_stage_md: RTL
=====================

// Module: execute_stage_md
// PURPOSE
//  Parametrised MIPS execute stage with ALU, 3-way operand forwarding, an iterative
//  multiply/divide unit with HI/LO registers, and the EX/MEM pipeline register.
//  Sits between the ID/EX register and the memory stage. Raises MDStallE to the hazard
//  unit while a multi-cycle MULT/DIV blocks a dependent instruction in E.
// PARAMETERS
//  DATA_W     32  datapath width (even, >=8)
//  REG_ADDR_W 5   register-file index width
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           synchronous, active-high
//  RegWriteE    in   1           E control: register write
//  MemtoRegE    in   1           E control: load result select
//  MemWriteE    in   1           E control: store
//  ALUControlE  in   3           ALU op (see BEHAVIOUR)
//  MDOpE        in   3           mul/div op (see BEHAVIOUR)
//  ALUSrcE      in   1           1: SrcB = SignImmE
//  RegDstE      in   1           1: WriteRegE = RdE, 0: RtE
//  FlushE       in   1           kill instruction in E (bubble to M, no MD start)
//  RtE, RdE     in   REG_ADDR_W  destination candidates
//  RD1E, RD2E   in   DATA_W      register operands
//  ForwardAE/BE in   2           00 RDxE, 01 ResultW, 10 ALUOutM, 11 RDxE
//  SignImmE     in   DATA_W      sign-extended immediate
//  ResultW      in   DATA_W      writeback value for forwarding
//  WriteRegE    out  REG_ADDR_W  combinational destination (to hazard unit)
//  MDStallE     out  1           combinational stall request
//  MDBusy       out  1           registered: MD unit state != IDLE
//  RegWriteM, MemtoRegM, MemWriteM  out 1 each   registered control
//  ALUOutM      out  DATA_W      registered result
//  WriteDataM   out  DATA_W      registered forwarded RD2 value (store data)
//  WriteRegM    out  REG_ADDR_W  registered destination
// BEHAVIOUR
//  Reset: all M outputs 0, HI=LO=0, MD state IDLE, counter 0, MDBusy 0. Reset during
//   BUSY aborts the operation; HI/LO read 0 afterwards.
//  SrcA = fwd(RD1E,ForwardAE); WriteDataE = fwd(RD2E,ForwardBE); SrcB = ALUSrcE ? SignImmE : WriteDataE.
//  ALUControlE: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SLTU, 110 SUB, 111 SLT;
//   add/sub wrap mod 2^DATA_W, no overflow flag; SLT/SLTU produce 0 or 1.
//  MDOpE: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MFHI, 110 MFLO, 111 none.
//  ResultE = MFHI ? HI : MFLO ? LO : ALU result.
//  MD FSM IDLE->BUSY: at edge with state IDLE, MDOpE in {MULT..DIVU}, !FlushE, !reset:
//   latch operand magnitudes (signed ops) or raw values (unsigned ops), record op, counter=0.
//  BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle, counter++;
//   on edge with counter==DATA_W-1: write HI/LO with sign correction, -> IDLE.
//   BUSY lasts exactly DATA_W cycles; new HI/LO visible to MFHI/MFLO in E on the next cycle.
//  MULT/MULTU: {HI,LO} = full 2*DATA_W-bit product.
//  DIV/DIVU: LO = quotient, HI = remainder; signed: quotient truncates toward zero,
//   remainder takes dividend sign. Divisor 0: LO = all ones, HI = dividend (no trap).
//   Signed MIN / -1: LO = MIN, HI = 0.
//  MDStallE = MDBusy && MDOpE in {MULT..MFLO} && !FlushE. While high, E instruction is
//   held (hazard unit stalls F/D/E) and M receives a bubble.
//  EX/MEM register each edge: if reset -> zeros; else if FlushE or MDStallE -> control
//   bits 0, data fields 0; else capture RegWrite/MemtoReg/MemWrite, ResultE, WriteDataE, WriteRegE.
//  ALU ops in E while MD is BUSY and MDOpE==none proceed normally (no stall).
//  MD-start instruction itself passes to M with its decoded controls (normally all 0).
// TESTING (DATA_W=32)
//  ALU: RD1E=1, RD2E=2, ALU ADD, ALUSrcE=0 -> ALUOutM=3 after 1 edge; ALUSrcE=1, SignImmE=5 -> 6.
//  Forwarding: ForwardAE=01, ResultW=13, RD2E=2, SUB -> ALUOutM=11; ForwardBE=10 uses previous ALUOutM.
//  MULT -3 x 7, then MFLO/MFHI held in E -> MDStallE=1 for 32 cycles, then LO=0xFFFFFFEB, HI=0xFFFFFFFF.
//  DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  FlushE=1 with MULTU issued -> MDBusy stays 0, M controls 0; reset at BUSY cycle 10 -> IDLE, HI=LO=0.
//  ADD in E while BUSY (MDOpE=000) -> no stall, ALUOutM correct next edge, HI/LO unaffected.

Source files
------------

// File: rtl/execute_stage_md.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_md
// Brief    : MIPS execute stage with ALU, operand forwarding, an iterative
//            multiply/divide unit with HI/LO, and the EX/MEM register.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage_md #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWriteE,
    input  logic                  MemtoRegE,
    input  logic                  MemWriteE,
    input  logic [2:0]            ALUControlE,
    input  logic [2:0]            MDOpE,
    input  logic                  ALUSrcE,
    input  logic                  RegDstE,
    input  logic                  FlushE,
    input  logic [REG_ADDR_W-1:0] RtE,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [DATA_W-1:0]     RD1E,
    input  logic [DATA_W-1:0]     RD2E,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    input  logic [DATA_W-1:0]     SignImmE,
    input  logic [DATA_W-1:0]     ResultW,
    output logic [REG_ADDR_W-1:0] WriteRegE,
    output logic                  MDStallE,
    output logic                  MDBusy,
    output logic                  RegWriteM,
    output logic                  MemtoRegM,
    output logic                  MemWriteM,
    output logic [DATA_W-1:0]     ALUOutM,
    output logic [DATA_W-1:0]     WriteDataM,
    output logic [REG_ADDR_W-1:0] WriteRegM
);

    localparam int              CNT_W      = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] c_MD_MULT  = 3'b001;
    localparam logic [2:0] c_MD_MULTU = 3'b010;
    localparam logic [2:0] c_MD_DIV   = 3'b011;
    localparam logic [2:0] c_MD_DIVU  = 3'b100;
    localparam logic [2:0] c_MD_MFHI  = 3'b101;
    localparam logic [2:0] c_MD_MFLO  = 3'b110;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    function automatic logic [DATA_W-1:0] fwd(input logic [DATA_W-1:0] rd,
                                              input logic [1:0]        sel,
                                              input logic [DATA_W-1:0] res_w,
                                              input logic [DATA_W-1:0] alu_m);
        case (sel)
            2'b01:   fwd = res_w;
            2'b10:   fwd = alu_m;
            default: fwd = rd;
        endcase
    endfunction

    logic [DATA_W-1:0] src_a, src_b, write_data_e, alu_res, result_e;

    assign src_a        = fwd(RD1E, ForwardAE, ResultW, ALUOutM);
    assign write_data_e = fwd(RD2E, ForwardBE, ResultW, ALUOutM);
    assign src_b        = ALUSrcE ? SignImmE : write_data_e;
    assign WriteRegE    = RegDstE ? RdE : RtE;

    always_comb begin
        alu_res = '0;
        case (ALUControlE)
            3'b000: alu_res = src_a & src_b;
            3'b001: alu_res = src_a | src_b;
            3'b010: alu_res = src_a + src_b;
            3'b011: alu_res = src_a ^ src_b;
            3'b100: alu_res = ~(src_a | src_b);
            3'b101: alu_res = {{(DATA_W-1){1'b0}}, (src_a < src_b)};
            3'b110: alu_res = src_a - src_b;
            3'b111: alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_res = '0;
        endcase
    end

    // ---------------------------------------------------------------- MD unit
    logic [0:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [DATA_W-1:0]   b_q, hi_q, lo_q;
    logic                is_div_q, neg_q, neg_rem_q, dz_q;

    logic md_start_op, md_signed_op, md_start_req;
    logic md_busy, md_start, md_last;

    assign md_start_op  = (MDOpE == c_MD_MULT) || (MDOpE == c_MD_MULTU) ||
                          (MDOpE == c_MD_DIV)  || (MDOpE == c_MD_DIVU);
    assign md_signed_op = (MDOpE == c_MD_MULT) || (MDOpE == c_MD_DIV);
    assign md_start_req = md_start_op && !FlushE;

    always_ff @(posedge clk) begin
        if (reset) state_q <= c_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (md_start_req) state_d = c_BUSY;
            c_BUSY:  if (cnt_q == c_CNT_LAST) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        md_busy  = (state_q == c_BUSY);
        md_start = (state_q == c_IDLE) && md_start_req;
        md_last  = (state_q == c_BUSY) && (cnt_q == c_CNT_LAST);
    end

    assign MDBusy   = md_busy;
    assign MDStallE = md_busy && (MDOpE >= c_MD_MULT) && (MDOpE <= c_MD_MFLO) && !FlushE;

    // Operate on magnitudes; signs are reapplied when HI/LO are written.
    logic [DATA_W-1:0] a_mag, b_mag;
    assign a_mag = (md_signed_op && src_a[DATA_W-1])        ? -src_a        : src_a;
    assign b_mag = (md_signed_op && write_data_e[DATA_W-1]) ? -write_data_e : write_data_e;

    logic [DATA_W:0]     mul_sum, div_trial;
    logic [2*DATA_W-1:0] mul_next, div_next, acc_step, prod_fix;
    logic [DATA_W-1:0]   hi_fin, lo_fin;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_sum, acc_q[DATA_W-1:1]};
        // Restoring step: shifted partial remainder is DATA_W+1 bits wide.
        div_trial = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, b_q};
        div_next  = div_trial[DATA_W] ? {acc_q[2*DATA_W-2:0], 1'b0}
                                      : {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        acc_step  = is_div_q ? div_next : mul_next;
        prod_fix  = neg_q ? -acc_step : acc_step;
        if (is_div_q) begin
            lo_fin = dz_q ? '1 : (neg_q ? -acc_step[DATA_W-1:0] : acc_step[DATA_W-1:0]);
            hi_fin = neg_rem_q ? -acc_step[2*DATA_W-1:DATA_W] : acc_step[2*DATA_W-1:DATA_W];
        end else begin
            lo_fin = prod_fix[DATA_W-1:0];
            hi_fin = prod_fix[2*DATA_W-1:DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (md_start) begin
            acc_q     <= {{DATA_W{1'b0}}, a_mag};
            b_q       <= b_mag;
            cnt_q     <= '0;
            is_div_q  <= (MDOpE == c_MD_DIV) || (MDOpE == c_MD_DIVU);
            neg_q     <= md_signed_op && (src_a[DATA_W-1] ^ write_data_e[DATA_W-1]);
            neg_rem_q <= md_signed_op && src_a[DATA_W-1];
            dz_q      <= (write_data_e == '0);
        end else if (md_busy) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CNT_W'(1);
            if (md_last) begin
                hi_q <= hi_fin;
                lo_q <= lo_fin;
            end
        end
    end

    assign result_e = (MDOpE == c_MD_MFHI) ? hi_q :
                      (MDOpE == c_MD_MFLO) ? lo_q : alu_res;

    // ------------------------------------------------------------ EX/MEM reg
    always_ff @(posedge clk) begin
        if (reset || FlushE || MDStallE) begin
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            WriteRegM  <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemtoRegM  <= MemtoRegE;
            MemWriteM  <= MemWriteE;
            ALUOutM    <= result_e;
            WriteDataM <= write_data_e;
            WriteRegM  <= WriteRegE;
        end
    end

endmodule
`default_nettype wire
